matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 64, setting the row display time in clk cycles (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1, which starts scanning when high and stops scanning at the next row boundary when low.
REQ-005 The block SHALL have port row_addr, output, 4, the frame-buffer row index being fetched.
REQ-006 The block SHALL have port row_data, input, 16, the frame-buffer row contents, valid one cycle after row_addr changes; bit 15 is the leftmost column.
REQ-007 The block SHALL have port swap_req, input, 1, a level request from the game logic to swap frame buffers.
REQ-008 The block SHALL have port swap_ack, output, 1, a one-cycle pulse granting a swap at a frame boundary.
REQ-009 The block SHALL have port frame_start, output, 1, a one-cycle pulse when the row-0 fetch begins.
REQ-010 The block SHALL have ports CSDI and CCLK, outputs, 1 each, the column shift-register data and clock.
REQ-011 The block SHALL have ports RSDI and RCLK, outputs, 1 each, the row shift-register data and clock.
REQ-012 The block SHALL have ports LE (active-high latch) and OEB (active-low output enable), outputs, 1 each.

Function
REQ-013 The block SHALL implement the states IDLE, FETCH, LOAD, COL, ROW, LATCH and SHOW.
REQ-014 In IDLE, the block SHALL hold OEB=1 and CCLK=RCLK=LE=0, and SHALL move to FETCH with row=0 when enable=1.
REQ-015 In FETCH (1 cycle), the block SHALL drive row_addr=row and pulse frame_start if row==0.
REQ-016 In LOAD (1 cycle), the block SHALL capture row_data into a 16-bit shift register.
REQ-017 In COL (32 cycles), for each bit MSB-first, the block SHALL drive CSDI=bit with CCLK=0 on the first cycle and hold CSDI with CCLK=1 on the second cycle.
REQ-018 In ROW (2 cycles), the block SHALL drive RSDI=1 if row==0 else 0, with RCLK=0 on the first cycle and RCLK=1 on the second.
REQ-019 In LATCH (1 cycle), the block SHALL drive LE=1 and OEB=1.
REQ-020 In SHOW (DWELL cycles), the block SHALL drive OEB=0 and LE=0.
REQ-021 Outside SHOW, the block SHALL hold OEB=1 except during COL and ROW of rows 1..15, where the previous row stays displayed (OEB=0).
REQ-022 Row period SHALL be 37+DWELL cycles (101 for the default DWELL).
REQ-023 On exit from SHOW, row SHALL increment modulo 16, wrapping from 15 to 0.
REQ-024 On exit from SHOW, the next state SHALL be IDLE if enable==0, otherwise FETCH.
REQ-025 When leaving SHOW with row==15, the block SHALL pulse swap_ack for exactly one cycle if swap_req==1 at that edge.
REQ-026 At most one swap_ack SHALL occur per frame, and swap_ack SHALL never occur mid-frame.
REQ-027 If swap_req rises while leaving row 15, that same edge SHALL count as the grant.
REQ-028 If enable falls mid-row, the block SHALL complete the current row, including SHOW, before entering IDLE.
REQ-029 A frame_start pulse and a swap_ack pulse SHALL never occur in the same cycle; swap_ack SHALL precede frame_start by 1 cycle.
REQ-030 The COL bit counter SHALL be 5 bits and the DWELL counter SHALL be 8 bits, with no other arithmetic.

Reset
REQ-031 On reset_n=0, the block SHALL immediately, without a clock, set state=IDLE, row=0, row_addr=0, OEB=1 and all other outputs to 0.
REQ-032 A reset asserted mid-row SHALL abandon the shift sequence, and the next enable SHALL restart at row 0.
REQ-033 Release of reset_n SHALL be synchronised by two flops before it affects state.

Verification
REQ-034 Reset release with enable=1 and row_data=16'hA5F0 SHALL produce frame_start 1 cycle after FETCH, then 16 CCLK rising edges with CSDI sampled on those edges equal to 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0.
REQ-035 With enable=1 held for 1 frame and DWELL=64, the bench SHALL see exactly 16 LE pulses 101 cycles apart, RSDI=1 only on the row-0 RCLK edge, and row_addr sequencing 0..15 and wrapping to 0.
REQ-036 With swap_req raised during row 7 and held, the bench SHALL see one swap_ack at the end of row 15, none at the end of row 7, and frame_start on the next cycle.
REQ-037 With enable dropped during row 3 COL, the bench SHALL see row 3 complete its LATCH and SHOW, then IDLE with OEB=1, row=4 and no further CCLK edges.
REQ-038 With reset_n pulsed low during row 9 SHOW, the bench SHALL see OEB=1 and row_addr=0 asynchronously, and the next frame_start SHALL follow re-enable.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// LED matrix scan controller: fetches one 16-bit frame-buffer row at a time, shifts it
// out to the column driver, steps the row driver, latches and displays it for DWELL cycles.
module matrix_scan_ctrl #(
    parameter int unsigned DWELL = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [3:0]  row_addr,
    input  logic [15:0] row_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic        CSDI,
    output logic        CCLK,
    output logic        RSDI,
    output logic        RCLK,
    output logic        LE,
    output logic        OEB
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, COL, ROW, LATCH, SHOW
    } state_e;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    // Reset asserts immediately but is released only after two clean clk edges.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    state_e      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] shreg_q, shreg_d;
    logic        swap_ack_q, swap_ack_d;
    logic        frame_start_q, frame_start_d;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= IDLE;
            row_q         <= '0;
            bit_cnt_q     <= '0;
            dwell_q       <= '0;
            shreg_q       <= '0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            bit_cnt_q     <= bit_cnt_d;
            dwell_q       <= dwell_d;
            shreg_q       <= shreg_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        bit_cnt_d     = bit_cnt_q;
        dwell_d       = dwell_q;
        shreg_d       = shreg_q;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        OEB           = 1'b1;
        LE            = 1'b0;
        CSDI          = 1'b0;
        CCLK          = 1'b0;
        RSDI          = 1'b0;
        RCLK          = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FETCH;
                    row_d   = 4'd0;
                end
            end
            FETCH: begin
                frame_start_d = (row_q == 4'd0);
                state_d       = LOAD;
            end
            LOAD: begin
                shreg_d   = row_data;
                bit_cnt_d = 5'd0;
                state_d   = COL;
            end
            COL: begin
                // Even count presents the bit, odd count clocks it; shift after the clock.
                CSDI      = shreg_q[15];
                CCLK      = bit_cnt_q[0];
                OEB       = (row_q == 4'd0);
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q[0]) shreg_d = {shreg_q[14:0], 1'b0};
                if (bit_cnt_q == 5'd31) state_d = ROW;
            end
            ROW: begin
                RSDI      = (row_q == 4'd0);
                RCLK      = bit_cnt_q[0];
                OEB       = (row_q == 4'd0);
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q[0]) state_d = LATCH;
            end
            LATCH: begin
                LE      = 1'b1;
                dwell_d = 8'd0;
                state_d = SHOW;
            end
            SHOW: begin
                OEB     = 1'b0;
                dwell_d = dwell_q + 8'd1;
                if (dwell_q == DWELL_LAST) begin
                    row_d      = row_q + 4'd1;
                    swap_ack_d = (row_q == 4'd15) && swap_req;
                    state_d    = enable ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign row_addr    = row_q;
    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: probe table on the first row, directed multi-cycle sequences,
// and a randomized run compared every cycle against a row-position model.
module tb_matrix_scan_ctrl;

    localparam int DW = 64;
    localparam int P  = 37 + DW;

    logic        clk = 1'b0;
    logic        reset_n, enable, swap_req;
    logic [15:0] row_data;
    logic [3:0]  row_addr;
    logic        swap_ack, frame_start, CSDI, CCLK, RSDI, RCLK, LE, OEB;

    logic [15:0] fb [16];
    assign row_data = fb[row_addr];

    matrix_scan_ctrl #(.DWELL(DW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .row_addr(row_addr),
        .row_data(row_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .CSDI(CSDI), .CCLK(CCLK), .RSDI(RSDI),
        .RCLK(RCLK), .LE(LE), .OEB(OEB)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Model: where we are inside the current row, counted from its FETCH cycle.
    bit          m_act, m_sa;
    int          m_row, m_pos, m_hold;
    logic [15:0] m_data;

    logic        prev_cclk, prev_rclk;
    logic [3:0]  prev_ra;
    logic        csdi_q [$];
    logic        rsdi_q [$];
    logic [3:0]  ra_q [$];
    int          le_t [$];
    int          sa_t [$];
    int          fs_t [$];

    typedef struct {
        int          rel;
        logic [11:0] exp;
        string       name;
    } probe_t;

    function automatic logic [11:0] mk(input int ra, input bit sa, input bit fs, input bit cd,
                                       input bit cc, input bit rd, input bit rc, input bit le,
                                       input bit oe);
        return {4'(ra), sa, fs, cd, cc, rd, rc, le, oe};
    endfunction

    function automatic logic [11:0] cur_out();
        return {row_addr, swap_ack, frame_start, CSDI, CCLK, RSDI, RCLK, LE, OEB};
    endfunction

    function automatic logic [11:0] exp_out();
        int k;
        if (!m_act || m_pos < 2) return mk(m_row, m_sa, m_act && m_pos == 1 && m_row == 0, 0, 0, 0, 0, 0, 1);
        if (m_pos < 34) begin
            k = m_pos - 2;
            return mk(m_row, m_sa, 0, m_data[15 - k/2], bit'(k % 2), 0, 0, 0, m_row == 0);
        end
        if (m_pos < 36) return mk(m_row, m_sa, 0, 0, 0, m_row == 0, bit'(m_pos - 34), 0, m_row == 0);
        if (m_pos == 36) return mk(m_row, m_sa, 0, 0, 0, 0, 0, 1, 1);
        return mk(m_row, m_sa, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        m_act = 0; m_sa = 0; m_row = 0; m_pos = 0; m_hold = 2; m_data = '0;
    endtask

    task automatic model_step();
        m_sa = 0;
        if (m_hold > 0) m_hold--;
        else if (!m_act) begin
            if (enable) begin m_act = 1; m_row = 0; m_pos = 0; end
        end else if (m_pos == P - 1) begin
            m_sa  = (m_row == 15) && swap_req;
            m_row = (m_row + 1) % 16;
            m_pos = 0;
            m_act = enable;
        end else begin
            if (m_pos == 1) m_data = fb[m_row];
            m_pos++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        @(negedge clk);
        cyc++;
        chk("cycle_outputs", 32'(cur_out()), 32'(exp_out()));
        if (CCLK && !prev_cclk) csdi_q.push_back(CSDI);
        if (RCLK && !prev_rclk) rsdi_q.push_back(RSDI);
        if (row_addr != prev_ra) ra_q.push_back(row_addr);
        if (LE)          le_t.push_back(cyc);
        if (swap_ack)    sa_t.push_back(cyc);
        if (frame_start) fs_t.push_back(cyc);
        prev_cclk = CCLK; prev_rclk = RCLK; prev_ra = row_addr;
    endtask

    task automatic wait_ra(input int v, input int bound, input string nm);
        int i = 0;
        while (row_addr != 4'(v) && i < bound) begin tick(); i++; end
        chk(nm, 32'(row_addr), 32'(v));
    endtask

    task automatic wait_out(input int idx, input int bound, input string nm);
        int i = 0;
        logic [11:0] o;
        o = cur_out();
        while (!o[idx] && i < bound) begin tick(); i++; o = cur_out(); end
        chk(nm, 32'(o[idx]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected end before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        probe_t      tbl [$];
        int          rel, gaps;
        logic [15:0] v16;
        logic [63:0] v64;

        // Offsets counted from the row-0 frame_start (LOAD) cycle; frame buffer holds A5F0.
        tbl.push_back('{0,   mk(0, 0, 1, 0, 0, 0, 0, 0, 1), "load_fs"});
        tbl.push_back('{1,   mk(0, 0, 0, 1, 0, 0, 0, 0, 1), "col_b15_setup"});
        tbl.push_back('{2,   mk(0, 0, 0, 1, 1, 0, 0, 0, 1), "col_b15_clk"});
        tbl.push_back('{3,   mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "col_b14_setup"});
        tbl.push_back('{4,   mk(0, 0, 0, 0, 1, 0, 0, 0, 1), "col_b14_clk"});
        tbl.push_back('{9,   mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "col_b11_setup"});
        tbl.push_back('{11,  mk(0, 0, 0, 1, 0, 0, 0, 0, 1), "col_b10_setup"});
        tbl.push_back('{18,  mk(0, 0, 0, 1, 1, 0, 0, 0, 1), "col_b7_clk"});
        tbl.push_back('{32,  mk(0, 0, 0, 0, 1, 0, 0, 0, 1), "col_b0_clk"});
        tbl.push_back('{33,  mk(0, 0, 0, 0, 0, 1, 0, 0, 1), "row0_rsdi"});
        tbl.push_back('{34,  mk(0, 0, 0, 0, 0, 1, 1, 0, 1), "row0_rclk"});
        tbl.push_back('{35,  mk(0, 0, 0, 0, 0, 0, 0, 1, 1), "latch"});
        tbl.push_back('{36,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "show_first"});
        tbl.push_back('{99,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "show_last"});
        tbl.push_back('{100, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), "row1_fetch"});
        tbl.push_back('{101, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), "row1_load"});
        tbl.push_back('{102, mk(1, 0, 0, 1, 0, 0, 0, 0, 0), "row1_col_oeb_low"});

        for (int i = 0; i < 16; i++) fb[i] = 16'hA5F0;
        reset_n = 1'b0; enable = 1'b0; swap_req = 1'b0;
        model_reset();
        prev_cclk = 0; prev_rclk = 0; prev_ra = 0;
        repeat (3) tick();
        chk("reset_state", 32'(cur_out()), 32'h001);

        // Release with enable high: first row shifts out A5F0 MSB-first.
        enable = 1'b1; reset_n = 1'b1;
        csdi_q.delete();
        wait_out(6, 20, "first_frame_start");
        rel = 0;
        foreach (tbl[i]) begin
            while (rel < tbl[i].rel) begin tick(); rel++; end
            chk(tbl[i].name, 32'(cur_out()), 32'(tbl[i].exp));
        end
        v16 = '0;
        foreach (csdi_q[i]) v16 = {v16[14:0], csdi_q[i]};
        chk("csdi_edge_count", 32'(csdi_q.size()), 32'd16);
        chk("csdi_on_cclk", 32'(v16), 32'h0000A5F0);

        // One full frame: LE spacing, RSDI only on row 0, row_addr sequence with wrap.
        for (int i = 0; i < 16; i++) fb[i] = 16'($urandom);
        wait_out(6, 1700, "frame2_start");
        le_t.delete(); rsdi_q.delete(); ra_q.delete(); sa_t.delete();
        repeat (16 * P) tick();
        chk("le_count", 32'(le_t.size()), 32'd16);
        gaps = 0;
        for (int i = 1; i < le_t.size(); i++) if (le_t[i] - le_t[i-1] != P) gaps++;
        chk("le_spacing", 32'(gaps), 32'd0);
        v16 = '0;
        foreach (rsdi_q[i]) v16 = {v16[14:0], rsdi_q[i]};
        chk("rclk_count", 32'(rsdi_q.size()), 32'd16);
        chk("rsdi_on_rclk", 32'(v16), 32'h00008000);
        v64 = '0;
        foreach (ra_q[i]) v64 = {v64[59:0], ra_q[i]};
        chk("row_addr_changes", 32'(ra_q.size()), 32'd16);
        chk("row_addr_seq_hi", v64[63:32], 32'h12345678);
        chk("row_addr_seq_lo", v64[31:0], 32'h9ABCDEF0);
        chk("no_swap_unrequested", 32'(sa_t.size()), 32'd0);

        // Swap request raised in row 7: granted only at the frame boundary.
        wait_ra(7, 1000, "reach_row7");
        swap_req = 1'b1;
        sa_t.delete();
        wait_out(7, 1700, "swap_ack_seen");
        chk("swap_at_row0_fetch", 32'(row_addr), 32'd0);
        chk("swap_single", 32'(sa_t.size()), 32'd1);
        tick();
        chk("fs_after_swap", 32'(frame_start), 32'd1);
        chk("swap_not_repeated", 32'(sa_t.size()), 32'd1);
        swap_req = 1'b0;

        // Enable dropped in row 3 COL: row finishes, then idles at row 4.
        wait_ra(3, 1700, "reach_row3");
        repeat (10) tick();
        enable = 1'b0;
        le_t.delete();
        repeat (150) tick();
        chk("le_after_drop", 32'(le_t.size()), 32'd1);
        chk("idle_row_addr", 32'(row_addr), 32'd4);
        chk("idle_oeb", 32'(OEB), 32'd1);
        csdi_q.delete();
        repeat (50) tick();
        chk("no_cclk_in_idle", 32'(csdi_q.size()), 32'd0);

        // Reset during row 9 SHOW acts without a clock; restart needs re-enable.
        enable = 1'b1;
        wait_ra(9, 1200, "reach_row9");
        wait_out(1, 120, "row9_latch");
        repeat (5) tick();
        #2;
        reset_n = 1'b0; enable = 1'b0;
        model_reset();
        #1;
        chk("async_reset_outputs", 32'(cur_out()), 32'h001);
        repeat (3) tick();
        reset_n = 1'b1;
        fs_t.delete();
        repeat (6) tick();
        chk("no_fs_while_disabled", 32'(fs_t.size()), 32'd0);
        enable = 1'b1;
        wait_out(6, 10, "fs_after_reenable");
        chk("fs_restart_row0", 32'(row_addr), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) swap_req = ~swap_req;
            if ($urandom_range(0, 199) == 0) fb[$urandom_range(0, 15)] = 16'($urandom);
            if (i == 2000) begin
                reset_n = 1'b0;
                model_reset();
                repeat (2) tick();
                reset_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
